// File: rtl/polara_tgen_pkg.sv
// rtl/polara_tgen_pkg.sv - shared encodings, header layout and LFSR constants for the traffic generator
// The LFSR constants are consumed only when POLARA_TGEN_LFSR_EN is defined.
package polara_tgen_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_HDR  = 3'd1,
      ST_DATA = 3'd2,
      ST_GAP  = 3'd3,
      ST_DONE = 3'd4
   } tgen_state_e;

   typedef enum logic [1:0] {
      MODE_ZERO = 2'd0,
      MODE_WALK = 2'd1,
      MODE_CNT  = 2'd2,
      MODE_LFSR = 2'd3
   } tgen_mode_e;

   localparam int HDR_CHIPID_W   = 14;
   localparam int HDR_X_W        = 8;
   localparam int HDR_Y_W        = 8;
   localparam int HDR_FBITS_W    = 4;
   localparam int HDR_LEN_W      = 8;
   localparam int HDR_MSG_W      = 8;
   localparam int HDR_MSHR_W     = 8;

   localparam int HDR_MSHR_OFF   = 6;
   localparam int HDR_MSG_OFF    = 14;
   localparam int HDR_LEN_OFF    = 22;
   localparam int HDR_FBITS_OFF  = 30;
   localparam int HDR_Y_OFF      = 34;
   localparam int HDR_X_OFF      = 42;
   localparam int HDR_CHIPID_OFF = 50;

   localparam logic [31:0] LFSR_POLY = 32'h8020_0003;
   localparam logic [31:0] LFSR_SEED = 32'hACE1_ACE1;

   // Bits [5:0] stay zero; the MSHR field carries the low byte of the packet index.
   function automatic logic [63:0] build_header(
      input logic [HDR_CHIPID_W-1:0] chipid,
      input logic [HDR_X_W-1:0]      x,
      input logic [HDR_Y_W-1:0]      y,
      input logic [HDR_FBITS_W-1:0]  fbits,
      input logic [HDR_LEN_W-1:0]    len,
      input logic [HDR_MSG_W-1:0]    msg,
      input logic [HDR_MSHR_W-1:0]   mshr
   );
      logic [63:0] h;
      h = '0;
      h[HDR_CHIPID_OFF +: HDR_CHIPID_W] = chipid;
      h[HDR_X_OFF      +: HDR_X_W]      = x;
      h[HDR_Y_OFF      +: HDR_Y_W]      = y;
      h[HDR_FBITS_OFF  +: HDR_FBITS_W]  = fbits;
      h[HDR_LEN_OFF    +: HDR_LEN_W]    = len;
      h[HDR_MSG_OFF    +: HDR_MSG_W]    = msg;
      h[HDR_MSHR_OFF   +: HDR_MSHR_W]   = mshr;
      return h;
   endfunction

endpackage

// File: rtl/polara_tgen_pattern.sv
// rtl/polara_tgen_pattern.sv - payload pattern source holding the run counter and optional LFSR
// POLARA_TGEN_LFSR_EN selects a real LFSR for mode 3; otherwise mode 3 reuses the counter.
module polara_tgen_pattern
   import polara_tgen_pkg::*;
#(
   parameter int W = 64
) (
   input  logic         clk_i,
   input  logic         rst_i,
   input  logic [1:0]   mode_i,
   input  logic [7:0]   k_i,
   input  logic         step_i,
   input  logic         clear_i,
   output logic [W-1:0] payload_o
);

   logic [31:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i)
         cnt_d = '0;
      else if (step_i)
         cnt_d = cnt_q + 32'd1;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

`ifdef POLARA_TGEN_LFSR_EN
   logic [31:0] lfsr_q, lfsr_d;

   // Right-shifting Galois form: the polynomial mask is folded in when bit 0 falls out.
   always_comb begin
      lfsr_d = lfsr_q;
      if (clear_i)
         lfsr_d = LFSR_SEED;
      else if (step_i)
         lfsr_d = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_POLY : 32'd0);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)
         lfsr_q <= LFSR_SEED;
      else
         lfsr_q <= lfsr_d;
   end
`endif

   always_comb begin
      payload_o = '0;
      case (tgen_mode_e'(mode_i))
         MODE_ZERO: payload_o = '0;
         MODE_WALK: begin
            for (int i = 0; i < W; i++)
               payload_o[i] = ((32'(k_i) % 32'(W)) == 32'(i));
         end
         MODE_CNT:  payload_o[31:0] = cnt_q;
`ifdef POLARA_TGEN_LFSR_EN
         MODE_LFSR: begin
            for (int i = 0; i < W; i++)
               payload_o[i] = lfsr_q[i % 32];
         end
`else
         MODE_LFSR: payload_o[31:0] = cnt_q;
`endif
         default:   payload_o = '0;
      endcase
   end

endmodule

// File: rtl/polara_noc_traffic_gen.sv
// rtl/polara_noc_traffic_gen.sv - chipset-side NoC packet generator with return-flit sink
// Build option POLARA_TGEN_LFSR_EN enables the LFSR payload pattern in the pattern sub-module.
module polara_noc_traffic_gen
   import polara_tgen_pkg::*;
#(
   parameter int NUM_NOCS       = 3,
   parameter int NOC_DATA_WIDTH = 64,
   parameter int CNT_W          = 16
) (
   input  logic                               chipset_clk,
   input  logic                               chip_rst,
   input  logic                               start,
   input  logic                               abort,
   input  logic [2:0]                         noc_sel,
   input  logic [1:0]                         mode,
   input  logic [7:0]                         payload_len,
   input  logic [CNT_W-1:0]                   num_pkts,
   input  logic [7:0]                         gap_cycles,
   input  logic [13:0]                        hdr_chipid,
   input  logic [7:0]                         hdr_x,
   input  logic [7:0]                         hdr_y,
   input  logic [3:0]                         hdr_fbits,
   input  logic [7:0]                         hdr_msg_type,
   output logic [NUM_NOCS*NOC_DATA_WIDTH-1:0] chipset_intf_data,
   output logic [NUM_NOCS-1:0]                chipset_intf_val,
   input  logic [NUM_NOCS-1:0]                chipset_intf_rdy,
   input  logic [NUM_NOCS*NOC_DATA_WIDTH-1:0] intf_chipset_data,
   input  logic [NUM_NOCS-1:0]                intf_chipset_val,
   output logic [NUM_NOCS-1:0]                intf_chipset_rdy,
   output logic                               busy,
   output logic                               done,
   output logic [CNT_W-1:0]                   pkts_sent,
   output logic [31:0]                        rx_flits
);

   localparam int W = NOC_DATA_WIDTH;

   tgen_state_e      state_q, state_d;
   logic [2:0]       sel_q;
   logic [1:0]       mode_q;
   logic [7:0]       len_q, gap_q, msg_q, x_q, y_q;
   logic [CNT_W-1:0] num_q;
   logic [13:0]      chipid_q;
   logic [3:0]       fbits_q;
   logic [CNT_W-1:0] pkts_q, pkts_d, pkts_inc;
   logic [7:0]       k_q, k_d;
   logic [7:0]       gap_cnt_q, gap_cnt_d;
   logic             abort_q, abort_d, abort_now;
   logic [31:0]      rx_q, rx_d;

   logic             sel_valid, cfg_load, pat_clear, pat_step, pkt_done;
   logic             tx_active, rdy_sel, fire;
   logic [W-1:0]     hdr_w, payload_w, flit_w;
   logic [3:0]       rx_inc;
   logic [32:0]      rx_sum;
   logic             unused_rx_data;

   assign unused_rx_data   = ^intf_chipset_data;
   assign intf_chipset_rdy = '1;

   assign sel_valid = (noc_sel != 3'd0) && ({29'd0, noc_sel} <= 32'(NUM_NOCS));
   assign abort_now = abort_q | abort;
   assign pkts_inc  = pkts_q + CNT_W'(1);
   assign tx_active = (state_q == ST_HDR) || (state_q == ST_DATA);
   assign fire      = tx_active & rdy_sel;

   always_comb begin
      state_d   = state_q;
      pkts_d    = pkts_q;
      k_d       = k_q;
      gap_cnt_d = gap_cnt_q;
      abort_d   = abort_q;
      cfg_load  = 1'b0;
      pat_clear = 1'b0;
      pat_step  = 1'b0;
      pkt_done  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            abort_d = 1'b0;
            if (start && sel_valid) begin
               cfg_load  = 1'b1;
               pat_clear = 1'b1;
               pkts_d    = '0;
               state_d   = ST_HDR;
            end
         end
         ST_HDR: begin
            abort_d = abort_now;
            if (fire) begin
               if (len_q == 8'd0) begin
                  pkt_done = 1'b1;
               end else begin
                  k_d     = 8'd0;
                  state_d = ST_DATA;
               end
            end
         end
         ST_DATA: begin
            abort_d = abort_now;
            if (fire) begin
               pat_step = 1'b1;
               if (k_q == len_q - 8'd1)
                  pkt_done = 1'b1;
               else
                  k_d = k_q + 8'd1;
            end
         end
         ST_GAP: begin
            abort_d = abort_now;
            if (abort_now)
               state_d = ST_DONE;
            else if (gap_cnt_q == 8'd1)
               state_d = ST_HDR;
            else
               gap_cnt_d = gap_cnt_q - 8'd1;
         end
         ST_DONE: begin
            if (!start)
               state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      // Abort is only honoured at a packet boundary so no packet is ever truncated.
      if (pkt_done) begin
         pkts_d = pkts_inc;
         if (((num_q != '0) && (pkts_inc == num_q)) || abort_now) begin
            state_d = ST_DONE;
         end else if (gap_q == 8'd0) begin
            state_d = ST_HDR;
         end else begin
            gap_cnt_d = gap_q;
            state_d   = ST_GAP;
         end
      end
   end

   always_ff @(posedge chipset_clk or posedge chip_rst) begin
      if (chip_rst) begin
         state_q   <= ST_IDLE;
         pkts_q    <= '0;
         k_q       <= '0;
         gap_cnt_q <= '0;
         abort_q   <= 1'b0;
         rx_q      <= '0;
      end else begin
         state_q   <= state_d;
         pkts_q    <= pkts_d;
         k_q       <= k_d;
         gap_cnt_q <= gap_cnt_d;
         abort_q   <= abort_d;
         rx_q      <= rx_d;
      end
   end

   always_ff @(posedge chipset_clk or posedge chip_rst) begin
      if (chip_rst) begin
         sel_q    <= '0;
         mode_q   <= '0;
         len_q    <= '0;
         num_q    <= '0;
         gap_q    <= '0;
         chipid_q <= '0;
         x_q      <= '0;
         y_q      <= '0;
         fbits_q  <= '0;
         msg_q    <= '0;
      end else if (cfg_load) begin
         sel_q    <= noc_sel;
         mode_q   <= mode;
         len_q    <= payload_len;
         num_q    <= num_pkts;
         gap_q    <= gap_cycles;
         chipid_q <= hdr_chipid;
         x_q      <= hdr_x;
         y_q      <= hdr_y;
         fbits_q  <= hdr_fbits;
         msg_q    <= hdr_msg_type;
      end
   end

   polara_tgen_pattern #(
      .W (W)
   ) u_pattern (
      .clk_i     (chipset_clk),
      .rst_i     (chip_rst),
      .mode_i    (mode_q),
      .k_i       (k_q),
      .step_i    (pat_step),
      .clear_i   (pat_clear),
      .payload_o (payload_w)
   );

   always_comb begin
      hdr_w       = '0;
      hdr_w[63:0] = build_header(chipid_q, x_q, y_q, fbits_q, len_q, msg_q, pkts_q[7:0]);
   end

   assign flit_w = (state_q == ST_HDR) ? hdr_w : payload_w;

   // Flit and valid only appear on the selected lane; every other lane is driven to zero.
   always_comb begin
      chipset_intf_data = '0;
      chipset_intf_val  = '0;
      rdy_sel           = 1'b0;
      for (int i = 0; i < NUM_NOCS; i++) begin
         if (tx_active && (sel_q == 3'(i + 1))) begin
            chipset_intf_val[i]        = 1'b1;
            chipset_intf_data[i*W +: W] = flit_w;
            rdy_sel                    = chipset_intf_rdy[i];
         end
      end
   end

   always_comb begin
      rx_inc = '0;
      for (int i = 0; i < NUM_NOCS; i++)
         rx_inc = rx_inc + {3'd0, intf_chipset_val[i] & intf_chipset_rdy[i]};
      rx_sum = {1'b0, rx_q} + {29'd0, rx_inc};
      rx_d   = rx_sum[32] ? 32'hFFFF_FFFF : rx_sum[31:0];
   end

   assign busy      = (state_q == ST_HDR) || (state_q == ST_DATA) || (state_q == ST_GAP);
   assign done      = (state_q == ST_DONE);
   assign pkts_sent = pkts_q;
   assign rx_flits  = rx_q;

endmodule
